// File: rtl/scale_pkg.sv
`default_nettype none
// ============================================================================
// Package     : scale_pkg
// Description : Shared types and defaults for the scale_* routing blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package scale_pkg;

    // Occupancy of a one-entry output holding slot
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Default data width of the routing blocks
    localparam int DEF_SIZE = 1;

endpackage : scale_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One destination port of the registered demux: a one-entry
//               holding register with valid/ready output handshake and a
//               wrapping count of delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
    import scale_pkg::*;
#(
    parameter int size  = DEF_SIZE,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             load,
    input  logic [size-1:0]  load_data,
    input  logic             out_ready,
    output logic [size-1:0]  out_data,
    output logic             out_valid,
    output logic             slot_ready,
    output logic [CNT_W-1:0] cnt
);

    slot_state_t      r_state;
    slot_state_t      w_state_next;
    logic             w_drain;
    logic [size-1:0]  r_data;
    logic [CNT_W-1:0] r_cnt;

    // Slot occupancy register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy: a load always wins (the slot only accepts a load when
    // empty or draining, so a load in FULL replaces the outgoing word)
    always_comb begin
        w_state_next = r_state;
        w_drain      = (r_state == SLOT_FULL) && out_ready;
        case (r_state)
            SLOT_EMPTY: begin
                if (load) begin
                    w_state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    w_state_next = SLOT_FULL;
                end else if (w_drain) begin
                    w_state_next = SLOT_EMPTY;
                end
            end
            default: begin
                w_state_next = SLOT_EMPTY;
            end
        endcase
    end

    // Data register loads only on accept for this port; drain leaves it alone
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= load_data;
        end
    end

    // Delivered-word counter, free-running modulo 2^CNT_W
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_data   = r_data;
    assign out_valid  = (r_state == SLOT_FULL);
    assign slot_ready = (r_state == SLOT_EMPTY) || out_ready;
    assign cnt        = r_cnt;

endmodule : demux_slot
`default_nettype wire

// File: rtl/scale_demux_reg.sv
`default_nettype none
// ============================================================================
// Module      : scale_demux_reg
// Description : Registered 1-to-2 demultiplexer. Each accepted input word is
//               steered by sel_a into the port A or port B holding slot.
// Revision    : 1.0 - initial release
// ============================================================================
module scale_demux_reg
    import scale_pkg::*;
#(
    parameter int size  = DEF_SIZE,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [size-1:0]  in_data,
    input  logic             in_valid,
    input  logic             sel_a,
    output logic             in_ready,
    output logic [size-1:0]  out_a,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [size-1:0]  out_b,
    output logic             out_b_valid,
    input  logic             out_b_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic w_ready_a;
    logic w_ready_b;
    logic w_accept;
    logic w_load_a;
    logic w_load_b;

    // Ready follows only the selected port so a stalled sink on the other
    // port never blocks traffic headed elsewhere
    always_comb begin
        in_ready = sel_a ? w_ready_a : w_ready_b;
        w_accept = in_valid && in_ready;
        w_load_a = w_accept && sel_a;
        w_load_b = w_accept && !sel_a;
    end

    demux_slot #(
        .size  (size),
        .CNT_W (CNT_W)
    ) u_slot_a (
        .clk        (clk),
        .rst_       (rst_),
        .load       (w_load_a),
        .load_data  (in_data),
        .out_ready  (out_a_ready),
        .out_data   (out_a),
        .out_valid  (out_a_valid),
        .slot_ready (w_ready_a),
        .cnt        (cnt_a)
    );

    demux_slot #(
        .size  (size),
        .CNT_W (CNT_W)
    ) u_slot_b (
        .clk        (clk),
        .rst_       (rst_),
        .load       (w_load_b),
        .load_data  (in_data),
        .out_ready  (out_b_ready),
        .out_data   (out_b),
        .out_valid  (out_b_valid),
        .slot_ready (w_ready_b),
        .cnt        (cnt_b)
    );

endmodule : scale_demux_reg
`default_nettype wire

// File: tb/tb_scale_demux_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_scale_demux_reg
// Description : Self-checking bench for scale_demux_reg (size=8, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scale_demux_reg;

    localparam int SIZE  = 8;
    localparam int CNT_W = 4;
    localparam int MODV  = 1 << CNT_W;

    logic             clk;
    logic             rst_;
    logic [SIZE-1:0]  in_data;
    logic             in_valid;
    logic             sel_a;
    logic             in_ready;
    logic [SIZE-1:0]  out_a;
    logic             out_a_valid;
    logic             out_a_ready;
    logic [SIZE-1:0]  out_b;
    logic             out_b_valid;
    logic             out_b_ready;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    int checks = 0;
    int errors = 0;

    // Reference model: each port is a queue of at most one word, plus the
    // last word ever loaded (the visible data) and a delivery count
    logic [SIZE-1:0] q_a[$];
    logic [SIZE-1:0] q_b[$];
    logic [SIZE-1:0] last_a, last_b;
    int              m_cnt_a, m_cnt_b;

    scale_demux_reg #(
        .size  (SIZE),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_        (rst_),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .sel_a       (sel_a),
        .in_ready    (in_ready),
        .out_a       (out_a),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_b       (out_b),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(input bit s, input bit ar, input bit br);
        if (s) return (q_a.size() == 0) || ar;
        else   return (q_b.size() == 0) || br;
    endfunction

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        last_a  = '0;
        last_b  = '0;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ":a_valid"}, out_a_valid, q_a.size() != 0);
        chk({tag, ":b_valid"}, out_b_valid, q_b.size() != 0);
        chk({tag, ":out_a"},   out_a, last_a);
        chk({tag, ":out_b"},   out_b, last_b);
        chk({tag, ":cnt_a"},   cnt_a, m_cnt_a);
        chk({tag, ":cnt_b"},   cnt_b, m_cnt_b);
    endtask

    // One clock cycle: drive at negedge, check in_ready mid-low-phase,
    // advance the model at the edge, check registered outputs at negedge
    task automatic step(input logic [SIZE-1:0] d, input bit v, input bit s,
                        input bit ar, input bit br, input string tag);
        bit exp_rdy;
        in_data     = d;
        in_valid    = v;
        sel_a       = s;
        out_a_ready = ar;
        out_b_ready = br;
        #2;
        exp_rdy = model_ready(s, ar, br);
        chk({tag, ":in_ready"}, in_ready, exp_rdy);
        @(posedge clk);
        if (q_a.size() != 0 && ar) begin
            void'(q_a.pop_front());
            m_cnt_a = (m_cnt_a + 1) % MODV;
        end
        if (q_b.size() != 0 && br) begin
            void'(q_b.pop_front());
            m_cnt_b = (m_cnt_b + 1) % MODV;
        end
        if (v && exp_rdy) begin
            if (s) begin q_a.push_back(d); last_a = d; end
            else   begin q_b.push_back(d); last_b = d; end
        end
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_        = 1'b0;
        in_valid    = 1'b0;
        out_a_ready = 1'b0;
        out_b_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        bit         v, s, ar, br;
        bit         e_rdy;
        bit         e_av;
        logic [7:0] e_a;
        bit         e_bv;
        logic [7:0] e_b;
        int         e_ca, e_cb;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // Directed vectors from a freshly reset block; expectations are the
        // state after the edge (e_rdy is in_ready before the edge)
        vecs[0] = '{8'hA5, 1, 1, 0, 0, 1, 1, 8'hA5, 0, 8'h00, 0, 0}; // route to A
        vecs[1] = '{8'h00, 0, 1, 1, 0, 1, 0, 8'hA5, 0, 8'h00, 1, 0}; // drain A
        vecs[2] = '{8'h11, 1, 1, 0, 0, 1, 1, 8'h11, 0, 8'h00, 1, 0}; // fill A
        vecs[3] = '{8'h22, 1, 1, 0, 0, 0, 1, 8'h11, 0, 8'h00, 1, 0}; // A stalled
        vecs[4] = '{8'h33, 1, 0, 0, 0, 1, 1, 8'h11, 1, 8'h33, 1, 0}; // B still open
        vecs[5] = '{8'h44, 1, 0, 0, 1, 1, 1, 8'h11, 1, 8'h44, 1, 1}; // B drain+load
        vecs[6] = '{8'h00, 0, 1, 1, 1, 1, 0, 8'h11, 0, 8'h44, 2, 2}; // both drain

        in_data = '0;
        sel_a   = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        #1;
        check_model("reset");
        chk("reset:a_valid0", out_a_valid, 0);
        chk("reset:cnt_a0", cnt_a, 0);
        sel_a = 1'b1; #1; chk("reset:rdy_sel1", in_ready, 1);
        sel_a = 1'b0; #1; chk("reset:rdy_sel0", in_ready, 1);
        @(negedge clk);

        // Table-driven directed vectors
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].d, vecs[i].v, vecs[i].s, vecs[i].ar, vecs[i].br, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d:t_a_valid", i), out_a_valid, vecs[i].e_av);
            chk($sformatf("vec%0d:t_out_a", i),   out_a,       vecs[i].e_a);
            chk($sformatf("vec%0d:t_b_valid", i), out_b_valid, vecs[i].e_bv);
            chk($sformatf("vec%0d:t_out_b", i),   out_b,       vecs[i].e_b);
            chk($sformatf("vec%0d:t_cnt_a", i),   cnt_a,       vecs[i].e_ca);
            chk($sformatf("vec%0d:t_cnt_b", i),   cnt_b,       vecs[i].e_cb);
        end

        // Streaming: 16 back-to-back words to A with sink always ready
        for (int i = 0; i < 16; i++) begin
            step(8'(i), 1, 1, 1, 0, $sformatf("stream%0d", i));
            chk($sformatf("stream%0d:word", i), out_a, i);
            chk($sformatf("stream%0d:valid", i), out_a_valid, 1);
        end
        step(8'h00, 0, 1, 1, 0, "stream_tail");
        chk("stream:cnt_a_total", cnt_a, (2 + 16) % MODV);

        // Counter wrap on B from a clean reset
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(8'(8'h80 + i), 1, 0, 0, 1, $sformatf("wrap%0d", i));
        end
        chk("wrap:cnt_b_allones", cnt_b, 15);
        step(8'h00, 0, 0, 0, 1, "wrap_tail");
        chk("wrap:cnt_b_zero", cnt_b, 0);

        // Mid-operation reset: both FULL with a nonzero counter
        step(8'h5A, 1, 1, 0, 0, "mr_fillA");
        step(8'h00, 0, 1, 1, 0, "mr_drainA");
        step(8'h6B, 1, 1, 0, 0, "mr_fillA2");
        step(8'hC3, 1, 0, 0, 0, "mr_fillB");
        in_valid = 1'b0;
        #2;
        rst_ = 1'b0;
        #1;
        chk("midrst:a_valid", out_a_valid, 0);
        chk("midrst:b_valid", out_b_valid, 0);
        chk("midrst:cnt_a", cnt_a, 0);
        chk("midrst:cnt_b", cnt_b, 0);
        chk("midrst:out_a", out_a, 0);
        model_reset();
        @(negedge clk);
        rst_ = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scale_demux_reg
`default_nettype wire

// File: doc/scale_demux_reg.md
Name: scale_demux_reg

Overview:
Registered 1-to-2 demultiplexer. It is the routing counterpart of scale_mux: scale_mux selects one of two sources onto a single output, while this block steers one input stream to one of two destinations. Each transfer on the input valid/ready handshake is captured into a one-entry output holding register for port A or port B, selected by sel_a. Each port has a wrapping transfer counter for bench and debug visibility.

Parameters:
size, 1, data width in bits of in_data, out_a and out_b (legal range 1..64)
CNT_W, 8, width of each per-port transfer counter

Ports:
clk  input  1  rising-edge clock
rst_  input  1  asynchronous active-low reset
in_data  input  size  data to route
in_valid  input  1  in_data and sel_a are valid this cycle
sel_a  input  1  1'b1 routes to port A, 1'b0 routes to port B; sampled with in_data
in_ready  output  1  block accepts in_data this cycle
out_a  output  size  port A data
out_a_valid  output  1  out_a holds an undelivered word
out_a_ready  input  1  port A sink accepts out_a
out_b  output  size  port B data
out_b_valid  output  1  out_b holds an undelivered word
out_b_ready  input  1  port B sink accepts out_b
cnt_a  output  CNT_W  count of words delivered on port A, wraps
cnt_b  output  CNT_W  count of words delivered on port B, wraps

Behaviour:
- Interface: one clock, clk; reset rst_ is asynchronous, active-low.
- Reset (rst_ low, asynchronously): out_a_valid=0, out_b_valid=0, out_a=0, out_b=0, cnt_a=0, cnt_b=0.
- Reset mid-operation: held words are discarded, no delivery is counted, and all state returns to reset values immediately.
- Each port is a 1-entry slot with two states:
  - EMPTY (valid=0)
  - FULL (valid=1)
- Port A slot transitions:
  - EMPTY -> FULL on accept with sel_a=1.
  - FULL -> EMPTY on drain (out_a_valid & out_a_ready) with no new accept for A.
  - FULL -> FULL on drain plus accept in the same cycle; out_a takes the new word.
- Port B slot behaves identically, with sel_a=0 and out_b_ready.
- in_ready is combinational:
  - sel_a=1: in_ready = !out_a_valid | out_a_ready
  - sel_a=0: in_ready = !out_b_valid | out_b_ready
- in_ready does not depend on in_valid. It does depend on the ready of the selected port only, never on the unselected port.
- Accept = in_valid & in_ready. Latency is 1 cycle: a word accepted at edge N is visible with valid=1 after edge N.
- Throughput is one word per cycle per port when the sink holds ready=1.
- Unselected port: its slot holds data and valid unchanged unless it is drained.
- Both ports may drain in the same cycle; each drain is independent.
- Output data registers load only on accept for that port; otherwise they hold. Data is not cleared on drain.
- Counters:
  - cnt_x increments by 1 on each drain of port x.
  - Modulo 2^CNT_W: all-ones + 1 = 0, with no saturation and no flag.
  - Both counters may increment in the same cycle.
- Sink protocol: the sink may raise ready at any time. The block never deasserts valid without a drain (except on reset).
- in_valid=1 with in_ready=0: the upstream must hold in_data and sel_a stable. The block does not check this.

Decomposition:
- Package scale_pkg holds:
  - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t
  - localparam DEF_SIZE = 1
- Sub-module demux_slot (parameter size) holds one port: data register, valid, ready logic and the CNT_W counter.
- The top instantiates demux_slot twice and generates the load enables from accept & sel_a and accept & !sel_a.

Test Plan:
1. Reset: hold rst_ low 3 cycles, then release. Then all valids=0, outputs=0, cnt_a=cnt_b=0, and in_ready=1 for either sel_a.
2. Single routing (size=8):
   - in_data=8'hA5, sel_a=1, in_valid for 1 cycle -> next cycle out_a=8'hA5, out_a_valid=1, out_b_valid=0.
   - Drain with out_a_ready=1 -> cnt_a=1.
3. Backpressure:
   - Fill A with 8'h11, out_a_ready=0, then present 8'h22 to A -> in_ready=0; out_a stays 8'h11.
   - Present 8'h33 with sel_a=0 -> accepted into B.
4. Streaming: out_a_ready=1, send 8'h00..8'h0F to A back-to-back -> one word per cycle, in order, no bubbles, cnt_a=16.
5. Wrap and simultaneous drain:
   - CNT_W=4: deliver 16 words on B -> cnt_b wraps to 0.
   - Fill both slots, then assert both readys in one cycle -> cnt_a and cnt_b each increment and both valids drop.
6. Reset mid-operation: both slots FULL with counters nonzero, pulse rst_ low between clock edges -> valids and counters clear immediately, before the next edge.
